serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor.
- Successor to the team's single-bit combinational full adder.
- Captures two N-bit operands with a start/ready handshake, then ripples BITS_PER_CYCLE full-adder slices per clock, LSB first.
- Reports sum, carry-out and signed overflow with a one-cycle done pulse. Used as a small-area arithmetic unit in the coursework datapath.

Parameters:
- N, 8: operand and result width in bits; N >= 2.
- BITS_PER_CYCLE, 1: full-adder slices evaluated per clock; must divide N exactly (elaboration error otherwise).

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- n_reset  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an operation; qualified by ready.
- ready  output  1  high when the block can accept start (IDLE state).
- A  input  N  operand A, sampled on the accept edge only.
- B  input  N  operand B, sampled on the accept edge only.
- SUB  input  1  0 = A + B + CIN; 1 = A - B - CIN; sampled on the accept edge.
- CIN  input  1  carry-in (add) or borrow-in (subtract); sampled on the accept edge.
- Y  output  N  result; registered, held until the next completion.
- COUT  output  1  raw carry out of bit N-1. For SUB this is the inverted borrow (1 = no borrow).
- OVF  output  1  two's-complement overflow = carry into bit N-1 XOR carry out of bit N-1.
- done  output  1  one-cycle pulse marking that Y/COUT/OVF were just updated.

Behaviour:
- Reset (n_reset low, asynchronous):
  - State goes to IDLE.
  - Y = 0, COUT = 0, OVF = 0, done = 0; internal step counter, carry and shift registers are cleared.
  - ready = 1 while in IDLE.
- Accept: on the rising edge where start && ready, capture:
  - A;
  - Beff = B XOR {N{SUB}};
  - initial carry = CIN XOR SUB.
  - State goes to RUN and the step counter is set to 0.
- start while ready = 0 is ignored and does not queue.
- States: IDLE, RUN.
  - ready = (state == IDLE), combinational from state.
- RUN: each edge processes BITS_PER_CYCLE bits.
  - Per slice: s = a ^ b ^ c; cnext = (a & b) | (a & c) | (b & c). This is the same full-adder function as the existing block, chained within the cycle.
  - The carry register holds the carry between cycles.
  - Sum bits accumulate in an internal shadow register. Y does not change during RUN.
- Completion: on the edge where the counter = STEPS-1 (STEPS = N / BITS_PER_CYCLE):
  - Y, COUT and OVF load the final values.
  - done is 1 for exactly the following cycle.
  - State returns to IDLE, so ready = 1 in the same cycle as done.
- Latency: done is high in cycle STEPS after the accept edge. Example: N=8, BITS_PER_CYCLE=1 gives 8 clocks; BITS_PER_CYCLE=8 gives 1 clock.
- Back-to-back: a start asserted during the done cycle is accepted (ready = 1). Throughput is one operation per STEPS cycles.
- Operand inputs may change freely after the accept edge without affecting the result in flight.
- Reset mid-RUN: the operation is aborted, no done pulse is produced, and outputs return to their reset values.
- Arithmetic is modulo 2^N. COUT and OVF are both computed for every operation, irrespective of operand signedness.

Test Plan:
- N=8, BPC=1; A=0x5A, B=0x3C, SUB=0, CIN=0 -> 8 cycles after accept: Y=0x96, COUT=0, OVF=1, done high exactly 1 cycle.
- N=8, BPC=1; A=0xFF, B=0x01, SUB=0, CIN=0 -> Y=0x00, COUT=1, OVF=0. Then A=0x7F, B=0x00, CIN=1 -> Y=0x80, COUT=0, OVF=1.
- N=8, BPC=1; A=0x10, B=0x20, SUB=1, CIN=0 -> Y=0xF0, COUT=0 (borrow), OVF=0. Then A=0x20, B=0x10, SUB=1, CIN=1 -> Y=0x0F, COUT=1.
- N=8, BPC=4; A=0xC8, B=0x64, SUB=0 -> done 2 cycles after accept, Y=0x2C, COUT=1, OVF=0. Also: start pulsed mid-RUN is ignored, and a start held during the done cycle is accepted immediately.
- Reset: drive n_reset low 3 cycles into a RUN (any clk phase) -> Y=0, COUT=0, OVF=0, done=0, ready=1 immediately. No done pulse after reset release.
- N=3, BPC=1 and BPC=3, exhaustive over all A, B, SUB, CIN (256 operations, back-to-back) -> every Y/COUT/OVF matches the reference model. Each 3-bit add column matches the existing 3-input truth table: A,B,C = 011 -> carry 1, sum 0; 111 -> carry 1, sum 1.

Source files
------------

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: captures two N-bit operands on a start/ready
// handshake, then ripples BITS_PER_CYCLE full-adder slices per clock, LSB first.
module serial_adder #(
  parameter int unsigned N              = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         start,
  output logic         ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         SUB,
  input  logic         CIN,
  output logic [N-1:0] Y,
  output logic         COUT,
  output logic         OVF,
  output logic         done
);

  localparam int unsigned BPC   = BITS_PER_CYCLE;
  localparam int unsigned STEPS = N / BPC;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  // Reject widths that cannot be split into whole slices.
  if ((N < 2) || ((N % BPC) != 0)) begin : g_param_check
    $error("serial_adder: N must be >= 2 and divisible by BITS_PER_CYCLE");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  state_t          state_next;
  logic [N-1:0]    a_sh;
  logic [N-1:0]    b_sh;
  logic [N-1:0]    sum_sh;
  logic [N-1:0]    sum_next;
  logic [BPC-1:0]  slice_s;
  logic [CW-1:0]   cnt;
  logic            carry;
  logic            c_run;
  logic            c_last_in;
  logic            c_final;
  logic            accept;
  logic            last;

  assign ready  = (state == IDLE);
  assign accept = start && ready;
  assign last   = (state == RUN) && (cnt == CW'(STEPS - 1));

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE until accepted, RUN for STEPS edges.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Chained full-adder slices for this cycle; sum bits enter the shadow from the top.
  always_comb begin
    slice_s   = '0;
    c_run     = carry;
    c_last_in = carry;
    for (int i = 0; i < int'(BPC); i++) begin
      c_last_in  = c_run;
      slice_s[i] = a_sh[i] ^ b_sh[i] ^ c_run;
      c_run      = (a_sh[i] & b_sh[i]) | (a_sh[i] & c_run) | (b_sh[i] & c_run);
    end
    c_final  = c_run;
    sum_next = (sum_sh >> BPC) | (N'(slice_s) << (N - BPC));
  end

  // Operand capture, per-cycle shifting and result loading on the final step.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      Y      <= '0;
      COUT   <= 1'b0;
      OVF    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sh   <= A;
        b_sh   <= B ^ {N{SUB}};
        carry  <= CIN ^ SUB;
        sum_sh <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        a_sh   <= a_sh >> BPC;
        b_sh   <= b_sh >> BPC;
        carry  <= c_final;
        sum_sh <= sum_next;
        cnt    <= cnt + CW'(1);
        if (last) begin
          Y    <= sum_next;
          COUT <= c_final;
          OVF  <= c_final ^ c_last_in;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: four configurations run in lockstep against an
// arithmetic reference model, checked every cycle, plus literal vectors.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [3:0] start_i;
  logic [7:0] a_i [4];
  logic [7:0] b_i [4];
  logic [3:0] sub_i;
  logic [3:0] cin_i;
  logic [3:0] ready_o;
  logic [3:0] done_o;
  logic [3:0] cout_o;
  logic [3:0] ovf_o;
  logic [7:0] y0;
  logic [7:0] y1;
  logic [2:0] y2;
  logic [2:0] y3;

  int total = 0;
  int bad   = 0;

  localparam int NW [4] = '{8, 8, 3, 3};
  localparam int SW [4] = '{8, 2, 3, 1};

  int busy [4];
  int rem  [4];
  int p_y  [4];
  int p_c  [4];
  int p_o  [4];
  int m_y  [4];
  int m_c  [4];
  int m_o  [4];
  int m_d  [4];
  int acc  [4];

  always #5 clk = ~clk;

  serial_adder #(.N(8), .BITS_PER_CYCLE(1)) u0 (
    .clk(clk), .n_reset(n_reset), .start(start_i[0]), .ready(ready_o[0]),
    .A(a_i[0]), .B(b_i[0]), .SUB(sub_i[0]), .CIN(cin_i[0]),
    .Y(y0), .COUT(cout_o[0]), .OVF(ovf_o[0]), .done(done_o[0]));

  serial_adder #(.N(8), .BITS_PER_CYCLE(4)) u1 (
    .clk(clk), .n_reset(n_reset), .start(start_i[1]), .ready(ready_o[1]),
    .A(a_i[1]), .B(b_i[1]), .SUB(sub_i[1]), .CIN(cin_i[1]),
    .Y(y1), .COUT(cout_o[1]), .OVF(ovf_o[1]), .done(done_o[1]));

  serial_adder #(.N(3), .BITS_PER_CYCLE(1)) u2 (
    .clk(clk), .n_reset(n_reset), .start(start_i[2]), .ready(ready_o[2]),
    .A(a_i[2][2:0]), .B(b_i[2][2:0]), .SUB(sub_i[2]), .CIN(cin_i[2]),
    .Y(y2), .COUT(cout_o[2]), .OVF(ovf_o[2]), .done(done_o[2]));

  serial_adder #(.N(3), .BITS_PER_CYCLE(3)) u3 (
    .clk(clk), .n_reset(n_reset), .start(start_i[3]), .ready(ready_o[3]),
    .A(a_i[3][2:0]), .B(b_i[3][2:0]), .SUB(sub_i[3]), .CIN(cin_i[3]),
    .Y(y3), .COUT(cout_o[3]), .OVF(ovf_o[3]), .done(done_o[3]));

  function automatic int y_of(input int k);
    case (k)
      0:       return int'(y0);
      1:       return int'(y1);
      2:       return int'(y2);
      default: return int'(y3);
    endcase
  endfunction

  // Reference arithmetic: modulo-2^n sum, carry out, sign-rule overflow.
  function automatic void calc(input int n, input int a, input int b, input int sub,
                               input int cin, output int y, output int c, output int o);
    int mask, beff, s, sa, sb, sy;
    mask = (1 << n) - 1;
    beff = (sub != 0) ? (~b & mask) : (b & mask);
    s    = (a & mask) + beff + (cin ^ sub);
    y    = s & mask;
    c    = (s >> n) & 1;
    sa   = ((a & mask) >> (n - 1)) & 1;
    sb   = (beff >> (n - 1)) & 1;
    sy   = (y >> (n - 1)) & 1;
    o    = (sa == sb && sy != sa) ? 1 : 0;
  endfunction

  task automatic check(input string nm, input int k, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", nm, k, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      busy[k] = 0; rem[k] = 0; acc[k] = 0;
      m_y[k] = 0; m_c[k] = 0; m_o[k] = 0; m_d[k] = 0;
    end
  endfunction

  // One rising edge of the model, using the inputs as seen before the edge.
  function automatic void model_edge();
    if (!n_reset) begin
      model_reset();
    end else begin
      for (int k = 0; k < 4; k++) begin
        acc[k] = 0;
        m_d[k] = 0;
        if (busy[k] != 0) begin
          rem[k]--;
          if (rem[k] == 0) begin
            busy[k] = 0;
            m_d[k]  = 1;
            m_y[k]  = p_y[k];
            m_c[k]  = p_c[k];
            m_o[k]  = p_o[k];
          end
        end else if (start_i[k]) begin
          busy[k] = 1;
          rem[k]  = SW[k];
          acc[k]  = 1;
          calc(NW[k], int'(a_i[k]), int'(b_i[k]), int'(sub_i[k]), int'(cin_i[k]),
               p_y[k], p_c[k], p_o[k]);
        end
      end
    end
  endfunction

  task automatic compare_all();
    for (int k = 0; k < 4; k++) begin
      check("ready", k, int'(ready_o[k]), (busy[k] != 0) ? 0 : 1);
      check("done",  k, int'(done_o[k]),  m_d[k]);
      check("y",     k, y_of(k),          m_y[k]);
      check("cout",  k, int'(cout_o[k]),  m_c[k]);
      check("ovf",   k, int'(ovf_o[k]),   m_o[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic rand_drive(input int k);
    start_i[k] = ($urandom_range(0, 3) != 0);
    a_i[k]     = 8'($urandom);
    b_i[k]     = 8'($urandom);
    sub_i[k]   = 1'($urandom);
    cin_i[k]   = 1'($urandom);
  endtask

  task automatic set_vec(input int k, input int v);
    a_i[k]   = 8'(v & 7);
    b_i[k]   = 8'((v >> 3) & 7);
    sub_i[k] = 1'((v >> 6) & 1);
    cin_i[k] = 1'((v >> 7) & 1);
  endtask

  task automatic wait_done(input int k, input int ey, input int ec, input int eo);
    int cyc;
    bit got;
    cyc = 0;
    got = 0;
    while (!got && cyc < 40) begin
      tick();
      cyc++;
      if (done_o[k]) got = 1;
    end
    check("latency", k, cyc, SW[k]);
    check("lit_y",   k, y_of(k), ey);
    check("lit_cout", k, int'(cout_o[k]), ec);
    check("lit_ovf", k, int'(ovf_o[k]), eo);
  endtask

  task automatic run_directed(input int k, input int a, input int b, input int sub,
                              input int cin, input int ey, input int ec, input int eo,
                              input bit hold);
    start_i[k] = 1'b1;
    a_i[k]     = 8'(a);
    b_i[k]     = 8'(b);
    sub_i[k]   = 1'(sub);
    cin_i[k]   = 1'(cin);
    tick();
    if (!hold) start_i[k] = 1'b0;
    wait_done(k, ey, ec, eo);
    if (hold) begin
      check("b2b_ready", k, int'(ready_o[k]), 1);
      tick();
      start_i[k] = 1'b0;
      check("b2b_accept", k, int'(ready_o[k]), 0);
      wait_done(k, ey, ec, eo);
    end
  endtask

  int ty, tc, to;
  int idx   [4];
  int ndone [4];
  int dcnt;

  initial begin
    n_reset = 1'b0;
    start_i = '0;
    sub_i   = '0;
    cin_i   = '0;
    for (int k = 0; k < 4; k++) begin
      a_i[k] = '0;
      b_i[k] = '0;
      idx[k] = 0;
      ndone[k] = 0;
    end
    model_reset();
    tick();
    tick();
    n_reset = 1'b1;
    tick();

    // Model pins: literal results, including the single-column truth table.
    calc(8, 'h5A, 'h3C, 0, 0, ty, tc, to);
    check("pin_5a3c_y", 0, ty, 'h96); check("pin_5a3c_o", 0, to, 1);
    calc(3, 1, 1, 0, 0, ty, tc, to);
    check("pin_col011", 2, ty, 2);
    calc(3, 1, 1, 0, 1, ty, tc, to);
    check("pin_col111", 2, ty, 3);
    calc(3, 7, 7, 0, 1, ty, tc, to);
    check("pin_777_y", 2, ty, 7); check("pin_777_c", 2, tc, 1);
    calc(3, 3, 1, 1, 0, ty, tc, to);
    check("pin_sub_y", 2, ty, 2); check("pin_sub_c", 2, tc, 1);

    // Directed vectors with literal expectations.
    run_directed(0, 'h5A, 'h3C, 0, 0, 'h96, 0, 1, 1'b0);
    run_directed(0, 'hFF, 'h01, 0, 0, 'h00, 1, 0, 1'b0);
    run_directed(0, 'h7F, 'h00, 0, 1, 'h80, 0, 1, 1'b0);
    run_directed(0, 'h10, 'h20, 1, 0, 'hF0, 0, 0, 1'b0);
    run_directed(0, 'h20, 'h10, 1, 1, 'h0F, 1, 0, 1'b0);
    run_directed(1, 'hC8, 'h64, 0, 0, 'h2C, 1, 0, 1'b1);
    tick();

    // Asynchronous reset in the middle of an operation.
    for (int k = 0; k < 4; k++) begin
      rand_drive(k);
      start_i[k] = 1'b1;
    end
    tick();
    start_i = '0;
    tick();
    tick();
    #3;
    n_reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    tick();
    tick();
    n_reset = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done_o[0]) dcnt++;
    end
    check("no_done_after_reset", 0, dcnt, 0);

    // Exhaustive 3-bit operations back-to-back, random traffic on the 8-bit units.
    set_vec(2, 0);
    set_vec(3, 0);
    start_i[2] = 1'b1;
    start_i[3] = 1'b1;
    for (int cyc = 0; cyc < 3000 && !(ndone[2] == 256 && ndone[3] == 256); cyc++) begin
      rand_drive(0);
      rand_drive(1);
      tick();
      for (int k = 2; k < 4; k++) begin
        if (done_o[k]) ndone[k]++;
        if (acc[k] != 0) begin
          idx[k]++;
          if (idx[k] < 256) set_vec(k, idx[k]);
          else start_i[k] = 1'b0;
        end
      end
    end
    check("exh_count", 2, ndone[2], 256);
    check("exh_count", 3, ndone[3], 256);

    // Fully random traffic on every configuration.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int k = 0; k < 4; k++) rand_drive(k);
      tick();
    end
    start_i = '0;
    repeat (12) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
